// File: rtl/irq_arbiter8_if.sv
// Request/mask/ack bundle between the interrupt consumer and irq_arbiter8.
// The master modport is the consumer side; the slave modport is the arbiter.
interface irq_arbiter8_if;
   logic [7:0] req;
   logic [7:0] mask;
   logic       ack;
   logic       irq;
   logic [2:0] vec;
   logic [7:0] pending;
   logic       busy;
   logic [7:0] count;

   modport master (output req, mask, ack, input irq, vec, pending, busy, count);
   modport slave  (input req, mask, ack, output irq, vec, pending, busy, count);
endinterface

// File: rtl/irq_arbiter8.sv
// Eight-line rising-edge interrupt arbiter with mask, MSB-first grant, irq/ack
// handshake and a wrapping count of completed handshakes.
module irq_arbiter8 (
   input  logic           clk,
   input  logic           rst,
   irq_arbiter8_if.slave  bus
);
   localparam int unsigned N_LINES = 8;
   localparam int unsigned VEC_W   = 3;

   typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;

   state_t               state;
   logic [N_LINES-1:0]   req_d;
   logic [N_LINES-1:0]   pending;
   logic [N_LINES-1:0]   rise;
   logic [N_LINES-1:0]   eligible;
   logic [N_LINES-1:0]   clr;
   logic [VEC_W-1:0]     top_idx;
   logic [VEC_W-1:0]     vec;
   logic [7:0]           count;
   logic                 irq;
   logic                 busy;

   always_comb rise     = bus.req & ~req_d;
   always_comb eligible = pending & ~bus.mask;

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      top_idx = '0;
      for (int i = 0; i < int'(N_LINES); i++) begin
         if (eligible[i]) top_idx = VEC_W'(i);
      end
   end

   // Clear only the granted line, and only on the ack that completes REQ.
   always_comb begin
      clr = '0;
      if (state == REQ && bus.ack) clr[vec] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_d   <= '0;
         pending <= '0;
         state   <= IDLE;
         irq     <= 1'b0;
         vec     <= '0;
         busy    <= 1'b0;
         count   <= '0;
      end else begin
         req_d   <= bus.req;
         pending <= rise | (pending & ~clr);
         case (state)
            IDLE: begin
               if (eligible != '0) begin
                  vec   <= top_idx;
                  irq   <= 1'b1;
                  busy  <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               if (bus.ack) begin
                  irq   <= 1'b0;
                  count <= count + 8'd1;
                  state <= ACKD;
               end
            end
            ACKD: begin
               if (!bus.ack) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               irq   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.irq     = irq;
   assign bus.vec     = vec;
   assign bus.pending = pending;
   assign bus.busy    = busy;
   assign bus.count   = count;
endmodule
